// File: rtl/mt_elastic_pipe_reg_pkg.sv
// rtl/mt_elastic_pipe_reg_pkg.sv - shared thread-id constants and types for the elastic pipe register
package mt_elastic_pipe_reg_pkg;

  // Default hardware thread count of the core.
  localparam int DEF_NUM_THREADS = 2;

  // Thread-id width: at least one bit even for a single-threaded core.
  function automatic int tid_width(input int num_threads);
    return (num_threads > 1) ? $clog2(num_threads) : 1;
  endfunction

  localparam int DEF_TID_W = tid_width(DEF_NUM_THREADS);

  typedef logic [DEF_TID_W-1:0] thread_id_t;

endpackage

// File: rtl/mt_pipe_compactor.sv
// rtl/mt_pipe_compactor.sv - combinational keep-mask to compacted slot image with optional append
module mt_pipe_compactor #(
  parameter  int DEPTH   = 2,
  parameter  int ENTRY_W = 8,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]              keep,
  input  logic [DEPTH-1:0][ENTRY_W-1:0] entries,
  input  logic                          append,
  input  logic [ENTRY_W-1:0]            append_entry,
  output logic [DEPTH-1:0][ENTRY_W-1:0] packed_entries,
  output logic [CNT_W-1:0]              next_count
);

  // Destination index of every slot: the number of kept slots ahead of it.
  logic [DEPTH-1:0][CNT_W-1:0] pos;
  logic [CNT_W-1:0]            survivors;

  // Prefix count over the keep mask; survivors ends as the total kept.
  always_comb begin : prefix_count
    survivors = '0;
    pos       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos[i] = survivors;
      if (keep[i]) begin
        survivors = survivors + CNT_W'(1);
      end
    end
  end

  // Each destination slot picks the single kept source mapped onto it, the
  // appended beat if it lands right after the survivors, or zero otherwise.
  // The parent only appends when a slot is free, so append never overflows.
  always_comb begin : slot_select
    packed_entries = '0;
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && (pos[i] == CNT_W'(j))) begin
          packed_entries[j] = entries[i];
        end
      end
      if (append && (survivors == CNT_W'(j))) begin
        packed_entries[j] = append_entry;
      end
    end
  end

  assign next_count = survivors + CNT_W'(append);

endmodule

// File: rtl/mt_elastic_pipe_reg.sv
// rtl/mt_elastic_pipe_reg.sv - thread-aware elastic stage register with per-thread selective flush
module mt_elastic_pipe_reg
  import mt_elastic_pipe_reg_pkg::*;
#(
  parameter  int DATA_W      = 64,
  parameter  int NUM_THREADS = DEF_NUM_THREADS,
  parameter  int DEPTH       = 2,
  localparam int TID_W       = tid_width(NUM_THREADS),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TID_W-1:0]       in_tid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TID_W-1:0]       out_tid,
  output logic [DATA_W-1:0]      out_data,
  input  logic [NUM_THREADS-1:0] flush_mask,
  output logic [CNT_W-1:0]       count
);

  localparam int ENTRY_W  = TID_W + DATA_W;
  // Flush mask widened to every encodable tid so a tid index is always in range.
  localparam int TID_SPAN = 1 << TID_W;

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("mt_elastic_pipe_reg: DEPTH must be within 1..8");
  end

  logic [DEPTH-1:0][ENTRY_W-1:0] slots;
  logic [DEPTH-1:0][ENTRY_W-1:0] slots_next;
  logic [CNT_W-1:0]              count_next;
  logic [TID_SPAN-1:0]           flush_span;
  logic [DEPTH-1:0]              keep;
  logic [TID_W-1:0]              head_tid;
  logic [TID_W-1:0]              slot_tid;
  logic                          pop;
  logic                          accept;
  logic                          append;

  assign flush_span = TID_SPAN'(flush_mask);
  assign head_tid   = slots[0][ENTRY_W-1 -: TID_W];

  // Head is always slot 0; a flushed head is hidden so it cannot handshake.
  assign out_tid   = head_tid;
  assign out_data  = slots[0][DATA_W-1:0];
  assign out_valid = (count != '0) && !flush_span[head_tid];

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready = rst_n && (count < CNT_W'(DEPTH));

  assign pop    = out_valid && out_ready;
  assign accept = in_valid && in_ready;
  // A flushed input still handshakes but is not stored.
  assign append = accept && !flush_span[in_tid];

  // Survivor mask: occupied, not of a flushed thread, and not the popped head.
  always_comb begin : keep_mask
    keep     = '0;
    slot_tid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_tid = slots[i][ENTRY_W-1 -: TID_W];
      keep[i]  = (CNT_W'(i) < count) && !flush_span[slot_tid];
    end
    if (pop) begin
      keep[0] = 1'b0;
    end
  end

  mt_pipe_compactor #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_compactor (
    .keep           (keep),
    .entries        (slots),
    .append         (append),
    .append_entry   ({in_tid, in_data}),
    .packed_entries (slots_next),
    .next_count     (count_next)
  );

  // Slot and count registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots <= '0;
      count <= '0;
    end else begin
      slots <= slots_next;
      count <= count_next;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

  for (genvar g = 0; g < DEPTH; g++) begin : g_vacant_check
    a_vacant_zero : assert property (@(posedge clk) disable iff (!rst_n)
      (CNT_W'(g) >= count) |-> (slots[g] == '0));
  end

endmodule

// File: tb/tb_mt_elastic_pipe_reg.sv
// tb/tb_mt_elastic_pipe_reg.sv - scoreboard bench for mt_elastic_pipe_reg
module tb_mt_elastic_pipe_reg;

  localparam int DATA_W      = 64;
  localparam int NUM_THREADS = 2;
  localparam int DEPTH       = 4;
  localparam int TID_W       = 1;
  localparam int CNT_W       = 3;

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [TID_W-1:0]       in_tid;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [TID_W-1:0]       out_tid;
  logic [DATA_W-1:0]      out_data;
  logic [NUM_THREADS-1:0] flush_mask;
  logic [CNT_W-1:0]       count;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  beat_t sb[$];

  mt_elastic_pipe_reg #(
    .DATA_W      (DATA_W),
    .NUM_THREADS (NUM_THREADS),
    .DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tid     (in_tid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tid    (out_tid),
    .out_data   (out_data),
    .flush_mask (flush_mask),
    .count      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  // Scoreboard: pop on head handshake, drop flushed threads, push accepted beats.
  always @(negedge clk) begin
    if (mon_en) begin
      automatic logic  exp_v;
      automatic beat_t e;
      automatic beat_t keep_q[$];
      exp_v = (sb.size() != 0) && !flush_mask[sb[0].tid];
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL sb_out_valid: got %0b expected %0b at %0t", out_valid, exp_v, $time);
      end
      checks++;
      if (count !== CNT_W'(sb.size())) begin
        errors++;
        $display("FAIL sb_count: got %0d expected %0d at %0t", count, sb.size(), $time);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: got beat %0h expected none at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          if ({out_tid, out_data} !== e) begin
            errors++;
            $display("FAIL sb_beat: got %0h:%0h expected %0h:%0h at %0t",
                     out_tid, out_data, e.tid, e.data, $time);
          end
        end
      end
      if (flush_mask != '0) begin
        foreach (sb[i]) if (!flush_mask[sb[i].tid]) keep_q.push_back(sb[i]);
        sb = keep_q;
      end
      if (in_valid && in_ready === 1'b1 && !flush_mask[in_tid]) begin
        sb.push_back('{tid: in_tid, data: in_data});
      end
      if (!rst_n) sb.delete();
    end
  end

  task automatic drive(input logic v, input logic [TID_W-1:0] t, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_tid   = t;
    in_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(0, 0, 0); out_ready = 1'b0; flush_mask = '0;
    repeat (2) step();
    @(negedge clk);
    checks += 5;
    if (count !== 0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    if (out_data !== 0)  begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    if (out_tid !== 0)   begin errors++; $display("FAIL reset_out_tid: got %0h expected 0", out_tid); end
    if (in_ready !== 0)  begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1) begin errors++; $display("FAIL reset_release_in_ready: got %0b expected 1", in_ready); end
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, DATA_W'(i));
      @(negedge clk);
      if (i > 1) begin
        checks += 2;
        if (out_data !== DATA_W'(i - 1)) begin errors++; $display("FAIL stream_data: got %0h expected %0h", out_data, i - 1); end
        if (count !== 1) begin errors++; $display("FAIL stream_count: got %0d expected 1", count); end
      end
      step();
    end
    drive(0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (out_data !== 64'h8) begin errors++; $display("FAIL stream_last: got %0h expected 8", out_data); end
    if (out_valid !== 1)    begin errors++; $display("FAIL stream_last_valid: got %0b expected 1", out_valid); end
    step();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] vals [4];
    vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC; vals[3] = 64'hD;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, vals[i]);
      step();
    end
    drive(1, 0, 64'hE);
    out_ready = 1'b1;
    @(negedge clk);
    checks += 3;
    if (count !== 4)        begin errors++; $display("FAIL bp_full_count: got %0d expected 4", count); end
    if (in_ready !== 0)     begin errors++; $display("FAIL bp_full_in_ready: got %0b expected 0", in_ready); end
    if (out_data !== 64'hA) begin errors++; $display("FAIL bp_head: got %0h expected a", out_data); end
    step();
    drive(0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1)     begin errors++; $display("FAIL bp_in_ready_return: got %0b expected 1", in_ready); end
    if (out_data !== 64'hB) begin errors++; $display("FAIL bp_second: got %0h expected b", out_data); end
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (count !== 0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", count); end
    step();
  endtask

  task automatic test_selective_flush();
    out_ready = 1'b0;
    drive(1, 1, 64'h10); step();
    drive(1, 0, 64'h20); step();
    drive(1, 1, 64'h30); step();
    drive(1, 0, 64'h40); step();
    drive(0, 0, 0);
    flush_mask = 2'b10;
    @(negedge clk);
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL sf_head_hidden: got %0b expected 0", out_valid); end
    step();
    flush_mask = 2'b00;
    @(negedge clk);
    checks += 2;
    if (count !== 2)        begin errors++; $display("FAIL sf_count: got %0d expected 2", count); end
    if (out_data !== 64'h20) begin errors++; $display("FAIL sf_head: got %0h expected 20", out_data); end
    out_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (count !== 0) begin errors++; $display("FAIL sf_drained: got %0d expected 0", count); end
    step();
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    drive(1, 0, 64'h1); step();
    drive(1, 1, 64'h2); step();
    drive(0, 0, 0);
    @(negedge clk);
    checks++;
    if (count !== 2) begin errors++; $display("FAIL sim_pre_count: got %0d expected 2", count); end
    step();
    out_ready = 1'b1;
    flush_mask = 2'b10;
    drive(1, 1, 64'h3);
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1)  begin errors++; $display("FAIL sim_in_handshake: got %0b expected 1", in_ready); end
    if (out_valid !== 1) begin errors++; $display("FAIL sim_pop: got %0b expected 1", out_valid); end
    step();
    flush_mask = 2'b00;
    drive(0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (count !== 0)     begin errors++; $display("FAIL sim_post_count: got %0d expected 0", count); end
    if (out_valid !== 0) begin errors++; $display("FAIL sim_post_valid: got %0b expected 0", out_valid); end
    step();
  endtask

  task automatic test_flushed_head();
    out_ready = 1'b0;
    drive(1, 0, 64'h5); step();
    drive(0, 0, 0);
    out_ready = 1'b1;
    flush_mask = 2'b01;
    @(negedge clk);
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL fh_valid: got %0b expected 0", out_valid); end
    step();
    flush_mask = 2'b00;
    @(negedge clk);
    checks += 2;
    if (count !== 0)     begin errors++; $display("FAIL fh_count: got %0d expected 0", count); end
    if (out_valid !== 0) begin errors++; $display("FAIL fh_post_valid: got %0b expected 0", out_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'(i), DATA_W'(64'h70 + i));
      step();
    end
    drive(0, 0, 0);
    @(negedge clk);
    checks++;
    if (count !== 3) begin errors++; $display("FAIL rm_pre_count: got %0d expected 3", count); end
    step();
    rst_n = 1'b0;
    drive(1, 0, 64'h99);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 0) begin errors++; $display("FAIL rm_in_ready_low: got %0b expected 0", in_ready); end
    step();
    rst_n = 1'b1;
    drive(0, 0, 0);
    out_ready = 1'b0;
    @(negedge clk);
    checks += 4;
    if (count !== 0)     begin errors++; $display("FAIL rm_count: got %0d expected 0", count); end
    if (out_valid !== 0) begin errors++; $display("FAIL rm_out_valid: got %0b expected 0", out_valid); end
    if (out_data !== 0)  begin errors++; $display("FAIL rm_out_data: got %0h expected 0", out_data); end
    if (in_ready !== 1)  begin errors++; $display("FAIL rm_in_ready: got %0b expected 1", in_ready); end
    step();
  endtask

  task automatic test_random_mix();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      out_ready  = 1'($urandom_range(0, 1));
      flush_mask = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step();
    end
    drive(0, 0, 0);
    flush_mask = 2'b00;
    out_ready  = 1'b1;
    repeat (DEPTH + 2) step();
    @(negedge clk);
    checks++;
    if (count !== 0) begin errors++; $display("FAIL rand_drained: got %0d expected 0", count); end
    step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_selective_flush();
    test_simultaneous();
    test_flushed_head();
    test_reset_mid();
    test_random_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
